packet_builder: RTL and testbench

PACKET_BUILDER -- requirements
Module: packet_builder

---
 rtl/packet_builder.sv | 102 ++++++++++
 tb/tb_packet_builder.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_builder.sv
// Packet builder: emits Ethernet/IPv4/TCP headers (MS word first) followed by
// PAYLOAD_WORDS payload words pulled one at a time from an upstream FIFO.
module packet_builder #(
  parameter int PAYLOAD_WORDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] eth_hdr,
  input  logic [159:0] ip_hdr,
  input  logic [159:0] tcp_hdr,
  input  logic [31:0]  pl_data,
  input  logic         pl_empty,
  output logic         pl_rd_en,
  output logic [31:0]  tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         tx_last,
  output logic         busy
);

  localparam logic [7:0] LAST_PL = 8'(PAYLOAD_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ETH,
    IP,
    TCP,
    PL_FETCH,
    PL_WAIT,
    PL_SEND
  } state_t;

  state_t        state, state_nx;
  logic [447:0]  hdr;
  logic [2:0]    word_cnt;
  logic [7:0]    pl_cnt;
  logic [31:0]   pl_word;
  logic          in_hdr;
  logic          hs;
  logic          sec_done;

  assign in_hdr   = state inside {ETH, IP, TCP};
  assign tx_valid = in_hdr || (state == PL_SEND);
  assign hs       = tx_valid && tx_ready;
  // ETH carries 4 words, IP and TCP carry 5 each.
  assign sec_done = (state == ETH) ? (word_cnt == 3'd3) : (word_cnt == 3'd4);
  assign tx_data  = in_hdr ? hdr[447:416] : pl_word;
  assign tx_last  = (state == PL_SEND) && (pl_cnt == LAST_PL);
  assign busy     = (state != IDLE);
  assign pl_rd_en = (state == PL_FETCH) && !pl_empty;

  always_comb begin
    // NOTE: default first, so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    case (state)
      IDLE:     if (start) state_nx = ETH;
      ETH:      if (hs && sec_done) state_nx = IP;
      IP:       if (hs && sec_done) state_nx = TCP;
      TCP:      if (hs && sec_done) state_nx = PL_FETCH;
      PL_FETCH: if (!pl_empty) state_nx = PL_WAIT;
      PL_WAIT:  state_nx = PL_SEND;
      PL_SEND:  if (hs) state_nx = (pl_cnt == LAST_PL) ? IDLE : PL_FETCH;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      // NOTE: the wide header register is reset as well, so no stale header
      // from an abandoned packet can ever reach tx_data.
      hdr      <= '0;
      word_cnt <= '0;
      pl_cnt   <= '0;
      pl_word  <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register here sees the
      // pre-edge values of the others regardless of statement order.
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            hdr      <= {eth_hdr, ip_hdr, tcp_hdr};
            word_cnt <= '0;
            pl_cnt   <= '0;
          end
        end
        ETH, IP, TCP: begin
          if (hs) begin
            hdr      <= {hdr[415:0], 32'h0};
            word_cnt <= sec_done ? 3'd0 : word_cnt + 3'd1;
          end
        end
        PL_WAIT: pl_word <= pl_data;
        PL_SEND: if (hs) pl_cnt <= pl_cnt + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_builder.sv
// Bench for packet_builder: two instances (10 and 1 payload words) share the
// stimulus; a word-level scoreboard predicts every handshake.
module tb_packet_builder;

  localparam int          PW0  = 10;
  localparam int          PW1  = 1;
  localparam logic [31:0] FILL = 32'hD4F40099;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         tx_ready;
  logic [127:0] eth;
  logic [159:0] ip;
  logic [159:0] tcp;

  logic [31:0] pl_data_v  [2];
  logic        empty_v    [2];
  logic        rd_v       [2];
  logic [31:0] tx_data_v  [2];
  logic        tx_valid_v [2];
  logic        tx_last_v  [2];
  logic        busy_v     [2];

  int n_cmp = 0;
  int n_bad = 0;

  logic stall      = 1'b0;
  logic rand_empty = 1'b0;
  logic const_mode = 1'b1;

  logic [31:0] pop0 [$];
  logic [31:0] pop1 [$];
  logic [31:0] log0 [$];

  bit           m_busy    [2];
  int           idx       [2];
  logic [447:0] cap       [2];
  bit           pv        [2];
  logic [31:0]  pdata     [2];
  logic         plast     [2];
  logic         pr;
  int           pkt_rd    [2];
  int           pkts_done [2];
  int           last_len  [2];
  int           last_flag [2];

  always #5 clk = ~clk;

  packet_builder #(.PAYLOAD_WORDS(PW0)) dut0 (
    .clk(clk), .rst(rst), .start(start),
    .eth_hdr(eth), .ip_hdr(ip), .tcp_hdr(tcp),
    .pl_data(pl_data_v[0]), .pl_empty(empty_v[0]), .pl_rd_en(rd_v[0]),
    .tx_data(tx_data_v[0]), .tx_valid(tx_valid_v[0]), .tx_ready(tx_ready),
    .tx_last(tx_last_v[0]), .busy(busy_v[0])
  );

  packet_builder #(.PAYLOAD_WORDS(PW1)) dut1 (
    .clk(clk), .rst(rst), .start(start),
    .eth_hdr(eth), .ip_hdr(ip), .tcp_hdr(tcp),
    .pl_data(pl_data_v[1]), .pl_empty(empty_v[1]), .pl_rd_en(rd_v[1]),
    .tx_data(tx_data_v[1]), .tx_valid(tx_valid_v[1]), .tx_ready(tx_ready),
    .tx_last(tx_last_v[1]), .busy(busy_v[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pw(input int d);
    return (d == 0) ? PW0 : PW1;
  endfunction

  function automatic int pop_size(input int d);
    return (d == 0) ? pop0.size() : pop1.size();
  endfunction

  function automatic logic [31:0] pop_take(input int d);
    if (d == 0) return pop0.pop_front();
    return pop1.pop_front();
  endfunction

  task automatic pop_put(input int d, input logic [31:0] w);
    if (d == 0) pop0.push_back(w);
    else        pop1.push_back(w);
  endtask

  // Scoreboard step for one instance, evaluated mid-cycle.
  task automatic sb(input int d);
    logic [31:0] exp_w;
    if (!rst) begin
      check($sformatf("reset_outputs_%0d", d),
            {tx_data_v[d], tx_valid_v[d], tx_last_v[d], rd_v[d], busy_v[d]}, 64'd0);
      m_busy[d] = 0;
      idx[d]    = 0;
      pkt_rd[d] = 0;
      if (d == 0) pop0.delete();
      else        pop1.delete();
      return;
    end
    check($sformatf("busy_%0d", d), busy_v[d], m_busy[d]);
    if (!m_busy[d]) check($sformatf("idle_valid_%0d", d), tx_valid_v[d], 0);
    if (rd_v[d]) begin
      check($sformatf("rd_while_empty_%0d", d), empty_v[d], 0);
      pkt_rd[d]++;
    end
    if (m_busy[d] && idx[d] >= 14 && pop_size(d) == 0)
      check($sformatf("valid_without_payload_%0d", d), tx_valid_v[d], 0);
    if (pv[d] && !pr)
      check($sformatf("hold_%0d", d), {tx_valid_v[d], tx_data_v[d], tx_last_v[d]},
            {1'b1, pdata[d], plast[d]});
    if (m_busy[d] && tx_valid_v[d] && tx_ready) begin
      exp_w = 32'h0;
      if (idx[d] < 14) begin
        exp_w = cap[d][447 - 32*idx[d] -: 32];
      end else begin
        check($sformatf("payload_available_%0d", d), pop_size(d) != 0, 1);
        if (pop_size(d) != 0) exp_w = pop_take(d);
      end
      check($sformatf("word_%0d_%0d", d, idx[d]), tx_data_v[d], exp_w);
      check($sformatf("last_%0d_%0d", d, idx[d]), tx_last_v[d], idx[d] == 13 + pw(d));
      if (d == 0) log0.push_back(tx_data_v[0]);
      if (tx_last_v[d]) last_flag[d] = idx[d] + 1;
      idx[d]++;
      if (idx[d] == 14 + pw(d)) begin
        check($sformatf("rd_pulses_%0d", d), pkt_rd[d], pw(d));
        m_busy[d]   = 0;
        last_len[d] = idx[d];
        pkts_done[d]++;
      end
    end else if (!m_busy[d] && start) begin
      m_busy[d] = 1;
      idx[d]    = 0;
      pkt_rd[d] = 0;
      cap[d]    = {eth, ip, tcp};
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) sb(d);
    pr = tx_ready;
    for (int d = 0; d < 2; d++) begin
      pv[d]    = tx_valid_v[d];
      pdata[d] = tx_data_v[d];
      plast[d] = tx_last_v[d];
    end
  end

  // Upstream FIFO model: data appears the cycle after a read strobe.
  initial begin : fifo_src
    logic        rd_s [2];
    logic [31:0] w;
    for (int d = 0; d < 2; d++) begin
      empty_v[d]   = 1'b1;
      pl_data_v[d] = 32'h0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) rd_s[d] = rd_v[d];
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (rd_s[d] && rst) begin
          w = const_mode ? FILL : $urandom();
          pl_data_v[d] = w;
          pop_put(d, w);
        end
        empty_v[d] = stall || (rand_empty && $urandom_range(0, 2) == 0);
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic rand_headers();
    eth = {$urandom(), $urandom(), $urandom(), $urandom()};
    ip  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    tcp = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // mode 0: ready high, 1: ready toggles, 2: random ready/headers/stray starts
  task automatic run_until_idle(input int mode, input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      case (mode)
        0: tx_ready = 1'b1;
        1: tx_ready = ~tx_ready;
        default: begin
          tx_ready = 1'($urandom_range(0, 1));
          rand_headers();
          start = busy_v[0] ? ($urandom_range(0, 7) == 0) : 1'b0;
        end
      endcase
      tick();
      if (!busy_v[0] && !busy_v[1] && !start) done = 1;
    end
    check("packet_done_in_budget", done, 1);
  endtask

  task automatic prep();
    log0.delete();
    for (int d = 0; d < 2; d++) begin
      last_flag[d] = 0;
      last_len[d]  = 0;
    end
  endtask

  // Hand-derived expectations for the constant A1/B2/C3/D4F40099 packet.
  task automatic pin_const(input string tag);
    check({tag, "_len"}, log0.size(), 24);
    if (log0.size() == 24) begin
      check({tag, "_w1"},  log0[0],  32'hA1A1A1A1);
      check({tag, "_w4"},  log0[3],  32'hA1A1A1A1);
      check({tag, "_w5"},  log0[4],  32'hB2B2B2B2);
      check({tag, "_w10"}, log0[9],  32'hC3C3C3C3);
      check({tag, "_w14"}, log0[13], 32'hC3C3C3C3);
      check({tag, "_w15"}, log0[14], 32'hD4F40099);
      check({tag, "_w24"}, log0[23], 32'hD4F40099);
    end
    check({tag, "_last_pos"}, last_flag[0], 24);
    check({tag, "_pw1_len"}, last_len[1], 15);
    check({tag, "_pw1_last_pos"}, last_flag[1], 15);
  endtask

  initial begin : stim
    int lows;
    int rd_in;
    int val_in;
    int done0;
    bit seen;
    bit hit;
    rst = 1'b0; start = 1'b0; tx_ready = 1'b0;
    eth = '0; ip = '0; tcp = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    eth = {4{32'hA1A1A1A1}};
    ip  = {5{32'hB2B2B2B2}};
    tcp = {5{32'hC3C3C3C3}};

    // Back-to-back transfer with tx_ready held high.
    prep();
    pulse_start();
    run_until_idle(0, 400);
    pin_const("ready_high");

    // tx_ready toggling every cycle.
    prep();
    tx_ready = 1'b1;
    pulse_start();
    run_until_idle(1, 800);
    pin_const("ready_toggle");

    // FIFO runs dry after three payload reads for 20 cycles.
    prep();
    tx_ready = 1'b1;
    pulse_start();
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick();
      if (pkt_rd[0] >= 3) hit = 1;
    end
    check("reached_third_read", hit, 1);
    stall = 1'b1;
    rd_in = 0;
    val_in = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i >= 2) begin
        rd_in  += int'(rd_v[0]);
        val_in += int'(tx_valid_v[0]);
      end
    end
    check("stall_rd_pulses", rd_in, 0);
    check("stall_valid_cycles", val_in, 0);
    check("stall_still_busy", busy_v[0], 1);
    stall = 1'b0;
    run_until_idle(0, 400);
    pin_const("stall");

    // Reset during the second IP word, then a fresh packet.
    prep();
    pulse_start();
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (idx[0] == 5) hit = 1;
      else tick();
    end
    check("reached_ip_word2", hit, 1);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++)
      check($sformatf("async_reset_%0d", d),
            {tx_data_v[d], tx_valid_v[d], tx_last_v[d], rd_v[d], busy_v[d]}, 64'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("idle_after_reset", busy_v[0], 0);
    prep();
    pulse_start();
    run_until_idle(0, 400);
    pin_const("after_reset");

    // start held high across several packets.
    tx_ready = 1'b1;
    done0 = pkts_done[0];
    lows = 0;
    seen = 0;
    start = 1'b1;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (busy_v[0]) seen = 1;
      else if (seen) lows++;
    end
    start = 1'b0;
    run_until_idle(0, 400);
    check("held_start_gap_seen", lows > 0, 1);
    check("held_start_packets", (pkts_done[0] - done0) >= 2, 1);

    // Randomized headers, payload, FIFO empties and back-pressure.
    const_mode = 1'b0;
    rand_empty = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rand_headers();
      repeat ($urandom_range(0, 3)) tick();
      pulse_start();
      run_until_idle(2, 3000);
    end
    rand_empty = 1'b0;
    tx_ready = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
